// File: rtl/video_frame_scheduler_pkg.sv
// Shared configuration for the video frame scheduler: default raster timing,
// frame-buffer geometry, swap FSM encoding and the frame-buffer address helper.
package video_frame_scheduler_pkg;

    localparam int unsigned H_ACTIVE_DEF     = 640;
    localparam int unsigned H_FP_DEF         = 16;
    localparam int unsigned H_SYNC_DEF       = 96;
    localparam int unsigned H_BP_DEF         = 48;
    localparam int unsigned V_ACTIVE_DEF     = 480;
    localparam int unsigned V_FP_DEF         = 10;
    localparam int unsigned V_SYNC_DEF       = 2;
    localparam int unsigned V_BP_DEF         = 33;
    localparam int unsigned READ_LATENCY_DEF = 1;

    localparam int unsigned FB_WIDTH  = 320;
    localparam int unsigned FB_HEIGHT = 240;
    localparam int unsigned POS_W     = 10;
    localparam int unsigned ADDR_W    = 17;
    localparam int unsigned FCNT_W    = 16;

    typedef enum logic [1:0] {
        SWAP_IDLE    = 2'd0,
        SWAP_PENDING = 2'd1,
        SWAP_RELEASE = 2'd2
    } swap_state_e;

    typedef struct packed {
        logic hsync_n;
        logic vsync_n;
        logic active;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hsync_n: 1'b1, vsync_n: 1'b1, active: 1'b0};

    // (y/2)*320 + x/2 as shift-add; 320 = 256 + 64
    function automatic logic [ADDR_W-1:0] fb_address(input logic [POS_W-1:0] x,
                                                     input logic [POS_W-1:0] y);
        logic [ADDR_W-1:0] row;
        logic [ADDR_W-1:0] col;
        row = ADDR_W'(y >> 1);
        col = ADDR_W'(x >> 1);
        return (row << 4'd8) + (row << 4'd6) + col;
    endfunction

endpackage

// File: rtl/video_frame_scheduler_if.sv
// Bundles the pixel-tick/swap handshake and the raster outputs of the scheduler.
// frame_count exists only when VIDEO_FRAME_COUNTER_EN is defined.
interface video_frame_scheduler_if;
    import video_frame_scheduler_pkg::*;

    logic                pixel_tick;
    logic                swap_request;
    logic                swap_ack;
    logic                frame_select_memory;
    logic [POS_W-1:0]    pixel_x_pos;
    logic [POS_W-1:0]    pixel_y_pos;
    logic [ADDR_W-1:0]   frame_read_address;
    logic                video_hsync;
    logic                video_vsync;
    logic                video_active;
`ifdef VIDEO_FRAME_COUNTER_EN
    logic [FCNT_W-1:0]   frame_count;
`endif

    modport master (
        output pixel_tick,
        output swap_request,
        input  swap_ack,
        input  frame_select_memory,
        input  pixel_x_pos,
        input  pixel_y_pos,
        input  frame_read_address,
        input  video_hsync,
        input  video_vsync,
        input  video_active
`ifdef VIDEO_FRAME_COUNTER_EN
        , input frame_count
`endif
    );

    modport slave (
        input  pixel_tick,
        input  swap_request,
        output swap_ack,
        output frame_select_memory,
        output pixel_x_pos,
        output pixel_y_pos,
        output frame_read_address,
        output video_hsync,
        output video_vsync,
        output video_active
`ifdef VIDEO_FRAME_COUNTER_EN
        , output frame_count
`endif
    );

endinterface

// File: rtl/video_frame_scheduler_sync_delay.sv
// video_sync_delay: tick-enabled shift register that delays {hsync_n, vsync_n, active}
// by DEPTH pixel ticks to line up with frame-buffer RAM read data.
module video_sync_delay
    import video_frame_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  tick_i,
    input  sync_t sync_i,
    output sync_t sync_o
);

    sync_t [DEPTH-1:0] stage_q;

    // Shift one stage per pixel tick; reset fills every stage with the idle pattern
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage_q[i] <= SYNC_IDLE;
            end
        end else if (tick_i) begin
            stage_q[0] <= sync_i;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign sync_o = stage_q[DEPTH-1];

endmodule

// File: rtl/video_frame_scheduler.sv
// Raster timing generator, frame-buffer read addressing and tear-free double-buffer swap.
// Optional VIDEO_FRAME_COUNTER_EN adds a 16-bit frame counter stepped at vblank entry.
module video_frame_scheduler
    import video_frame_scheduler_pkg::*;
#(
    parameter int unsigned H_ACTIVE     = H_ACTIVE_DEF,
    parameter int unsigned H_FP         = H_FP_DEF,
    parameter int unsigned H_SYNC       = H_SYNC_DEF,
    parameter int unsigned H_BP         = H_BP_DEF,
    parameter int unsigned V_ACTIVE     = V_ACTIVE_DEF,
    parameter int unsigned V_FP         = V_FP_DEF,
    parameter int unsigned V_SYNC       = V_SYNC_DEF,
    parameter int unsigned V_BP         = V_BP_DEF,
    parameter int unsigned READ_LATENCY = READ_LATENCY_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    video_frame_scheduler_if.slave vif
);

    localparam int unsigned H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DELAY_DEPTH = (READ_LATENCY == 0) ? 1 : READ_LATENCY;

    localparam logic [POS_W-1:0] H_LAST       = POS_W'(H_TOTAL - 1);
    localparam logic [POS_W-1:0] V_LAST       = POS_W'(V_TOTAL - 1);
    localparam logic [POS_W-1:0] H_ACT        = POS_W'(H_ACTIVE);
    localparam logic [POS_W-1:0] V_ACT        = POS_W'(V_ACTIVE);
    localparam logic [POS_W-1:0] V_ACT_LAST   = POS_W'(V_ACTIVE - 1);
    localparam logic [POS_W-1:0] H_SYNC_FIRST = POS_W'(H_ACTIVE + H_FP);
    localparam logic [POS_W-1:0] H_SYNC_LAST  = POS_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [POS_W-1:0] V_SYNC_FIRST = POS_W'(V_ACTIVE + V_FP);
    localparam logic [POS_W-1:0] V_SYNC_LAST  = POS_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [POS_W-1:0]  x_q, x_d;
    logic [POS_W-1:0]  y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    swap_state_e       state_q, state_d;
    logic              fsel_q, fsel_d;
    logic              ack_q, ack_d;
    logic              vblank_entry_s;
    sync_t             sync_in_s;
    sync_t             sync_out_s;

    function automatic sync_t raster_sync(input logic [POS_W-1:0] x, input logic [POS_W-1:0] y);
        sync_t s;
        s.hsync_n = !((x >= H_SYNC_FIRST) && (x <= H_SYNC_LAST));
        s.vsync_n = !((y >= V_SYNC_FIRST) && (y <= V_SYNC_LAST));
        s.active  = (x < H_ACT) && (y < V_ACT);
        return s;
    endfunction

    // Next raster position and the read address that belongs to it
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (vif.pixel_tick) begin
            if (x_q == H_LAST) begin
                x_d = {POS_W{1'b0}};
                if (y_q == V_LAST) begin
                    y_d = {POS_W{1'b0}};
                end else begin
                    y_d = y_q + 10'd1;
                end
            end else begin
                x_d = x_q + 10'd1;
            end
        end else begin
            x_d = x_q;
        end
        if ((x_d < H_ACT) && (y_d < V_ACT)) begin
            addr_d = fb_address(x_d, y_d);
        end else begin
            addr_d = {ADDR_W{1'b0}};
        end
    end

    // Raster position and address registers, advanced only by pixel ticks
    always_ff @(posedge clock) begin
        if (reset) begin
            x_q    <= {POS_W{1'b0}};
            y_q    <= {POS_W{1'b0}};
            addr_q <= {ADDR_W{1'b0}};
        end else if (vif.pixel_tick) begin
            x_q    <= x_d;
            y_q    <= y_d;
            addr_q <= addr_d;
        end
    end

    // Latency 0 registers the new position's sync; otherwise the pre-tick position enters the chain
    generate
        if (READ_LATENCY == 0) begin : g_direct
            assign sync_in_s = raster_sync(x_d, y_d);
        end else begin : g_delayed
            assign sync_in_s = raster_sync(x_q, y_q);
        end
    endgenerate

    video_sync_delay #(
        .DEPTH (DELAY_DEPTH)
    ) u_sync_delay (
        .clock  (clock),
        .reset  (reset),
        .tick_i (vif.pixel_tick),
        .sync_i (sync_in_s),
        .sync_o (sync_out_s)
    );

    // The tick that moves the raster onto (0, V_ACTIVE), i.e. the first blanking line
    assign vblank_entry_s = vif.pixel_tick && (x_q == H_LAST) && (y_q == V_ACT_LAST);

    // Swap FSM next state: the request is latched, so a dropped request still commits
    always_comb begin
        state_d = state_q;
        fsel_d  = fsel_q;
        ack_d   = 1'b0;
        case (state_q)
            SWAP_IDLE: begin
                if (vif.swap_request) begin
                    state_d = SWAP_PENDING;
                end else begin
                    state_d = SWAP_IDLE;
                end
            end
            SWAP_PENDING: begin
                if (vblank_entry_s) begin
                    fsel_d  = ~fsel_q;
                    ack_d   = 1'b1;
                    state_d = SWAP_RELEASE;
                end else begin
                    state_d = SWAP_PENDING;
                end
            end
            SWAP_RELEASE: begin
                if (!vif.swap_request) begin
                    state_d = SWAP_IDLE;
                end else begin
                    state_d = SWAP_RELEASE;
                end
            end
            default: begin
                state_d = SWAP_IDLE;
            end
        endcase
    end

    // Swap FSM state, displayed-buffer select and acknowledge pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= SWAP_IDLE;
            fsel_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fsel_q  <= fsel_d;
            ack_q   <= ack_d;
        end
    end

`ifdef VIDEO_FRAME_COUNTER_EN
    logic [FCNT_W-1:0] frame_count_q;

    // Frame counter, wraps naturally at 16 bits
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_count_q <= {FCNT_W{1'b0}};
        end else if (vblank_entry_s) begin
            frame_count_q <= frame_count_q + 16'd1;
        end
    end

    assign vif.frame_count = frame_count_q;
`endif

    assign vif.pixel_x_pos         = x_q;
    assign vif.pixel_y_pos         = y_q;
    assign vif.frame_read_address  = addr_q;
    assign vif.frame_select_memory = fsel_q;
    assign vif.swap_ack            = ack_q;
    assign vif.video_hsync         = sync_out_s.hsync_n;
    assign vif.video_vsync         = sync_out_s.vsync_n;
    assign vif.video_active        = sync_out_s.active;

endmodule

// File: tb/tb_video_frame_scheduler.sv
// Self-checking bench for video_frame_scheduler on a reduced raster (24x17, latency 2),
// compared against a tick-count based reference model.
module tb_video_frame_scheduler;

    localparam int HA = 16, HFP = 2, HS = 4, HBP = 2, HT = HA + HFP + HS + HBP;
    localparam int VA = 12, VFP = 1, VS = 2, VBP = 2, VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;
    localparam int LAT = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    video_frame_scheduler_if vif();

    video_frame_scheduler #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .READ_LATENCY(LAT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .vif   (vif)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: raster derived purely from ticks since reset
    int m_t;
    bit m_fsel, m_ack, m_armed, m_rel;
    int m_fc;

    function automatic int ex_x(); return (m_t % FRAME) % HT; endfunction
    function automatic int ex_y(); return (m_t % FRAME) / HT; endfunction
    function automatic int ex_addr();
        if (ex_x() < HA && ex_y() < VA) return (ex_y() / 2) * 320 + ex_x() / 2;
        return 0;
    endfunction
    // which: 0 hsync, 1 vsync, 2 active; value as seen LAT ticks late
    function automatic bit ex_sync(int which);
        int p, x, y;
        if (m_t < LAT) return (which == 2) ? 1'b0 : 1'b1;
        p = (m_t - LAT) % FRAME;
        x = p % HT;
        y = p / HT;
        if (which == 0) return !(x >= HA + HFP && x < HA + HFP + HS);
        if (which == 1) return !(y >= VA + VFP && y < VA + VFP + VS);
        return (x < HA) && (y < VA);
    endfunction

    function automatic void model_update(bit tick, bit req);
        bit vbl;
        if (reset) begin
            m_t = 0; m_fsel = 0; m_ack = 0; m_armed = 0; m_rel = 0; m_fc = 0;
        end else begin
            vbl = tick && ((m_t % FRAME) == VA * HT - 1);
            m_ack = 0;
            if (m_armed) begin
                if (vbl) begin m_fsel = !m_fsel; m_ack = 1; m_armed = 0; m_rel = 1; end
            end else if (m_rel) begin
                if (!req) m_rel = 0;
            end else if (req) begin
                m_armed = 1;
            end
            if (vbl) m_fc = (m_fc + 1) % 65536;
            if (tick) m_t++;
        end
    endfunction

    task automatic step(input bit tick, input bit req);
        vif.pixel_tick   = tick;
        vif.swap_request = req;
        @(posedge clock);
        model_update(tick, req);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic run_to(input int tx, input int ty, input bit req);
        int n = 0;
        while (!(ex_x() == tx && ex_y() == ty) && n < 2 * FRAME) begin
            step(1'b1, req);
            n++;
        end
        checks++;
        if (n >= 2 * FRAME) begin
            errors++;
            $display("FAIL run_to_timeout: target (%0d,%0d) not reached, at (%0d,%0d)", tx, ty, ex_x(), ex_y());
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks += 8;
        if (vif.pixel_x_pos !== 10'd0) begin errors++; $display("FAIL reset_x: got %0d want 0", vif.pixel_x_pos); end
        if (vif.pixel_y_pos !== 10'd0) begin errors++; $display("FAIL reset_y: got %0d want 0", vif.pixel_y_pos); end
        if (vif.frame_select_memory !== 1'b0) begin errors++; $display("FAIL reset_fsel: got %b want 0", vif.frame_select_memory); end
        if (vif.swap_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", vif.swap_ack); end
        if (vif.frame_read_address !== 17'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", vif.frame_read_address); end
        if (vif.video_hsync !== 1'b1) begin errors++; $display("FAIL reset_hsync: got %b want 1", vif.video_hsync); end
        if (vif.video_vsync !== 1'b1) begin errors++; $display("FAIL reset_vsync: got %b want 1", vif.video_vsync); end
        if (vif.video_active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b want 0", vif.video_active); end
    endtask

    task automatic test_full_frame();
        int wraps = 0, hlow = 0;
        do_reset();
        for (int i = 0; i < FRAME; i++) begin
            step(1'b1, 1'b0);
            checks += 2;
            if (vif.pixel_x_pos !== ex_x()) begin errors++; $display("FAIL frame_x: got %0d want %0d", vif.pixel_x_pos, ex_x()); end
            if (vif.pixel_y_pos !== ex_y()) begin errors++; $display("FAIL frame_y: got %0d want %0d", vif.pixel_y_pos, ex_y()); end
            if (vif.pixel_x_pos == 10'd0 && vif.pixel_y_pos == 10'd0) wraps++;
            if (vif.video_hsync == 1'b0) hlow++;
        end
        checks += 2;
        if (wraps !== 1) begin errors++; $display("FAIL frame_wraps: got %0d want 1", wraps); end
        if (hlow !== HS * VT) begin errors++; $display("FAIL hsync_low_ticks: got %0d want %0d", hlow, HS * VT); end
    endtask

    task automatic test_sparse_tick();
        logic [9:0] px, py;
        logic ph;
        do_reset();
        px = vif.pixel_x_pos; py = vif.pixel_y_pos; ph = vif.video_hsync;
        for (int c = 0; c < 240; c++) begin
            step((c % 4) == 0, 1'b0);
            checks += 2;
            if (vif.pixel_x_pos !== ex_x()) begin errors++; $display("FAIL sparse_x: got %0d want %0d", vif.pixel_x_pos, ex_x()); end
            if ((c % 4) != 0) begin
                checks += 1;
                if (vif.pixel_x_pos !== px || vif.pixel_y_pos !== py || vif.video_hsync !== ph) begin
                    errors++;
                    $display("FAIL sparse_hold: got (%0d,%0d,%b) want (%0d,%0d,%b)",
                             vif.pixel_x_pos, vif.pixel_y_pos, vif.video_hsync, px, py, ph);
                end
            end
            if (vif.pixel_y_pos !== ex_y()) begin errors++; $display("FAIL sparse_y: got %0d want %0d", vif.pixel_y_pos, ex_y()); end
            px = vif.pixel_x_pos; py = vif.pixel_y_pos; ph = vif.video_hsync;
        end
    endtask

    task automatic test_address_points();
        do_reset();
        run_to(2, 3, 1'b0);
        checks++;
        if (vif.frame_read_address !== 17'd321) begin errors++; $display("FAIL addr_2_3: got %0d want 321", vif.frame_read_address); end
        run_to(HA - 1, VA - 1, 1'b0);
        checks++;
        if (vif.frame_read_address !== 17'd1607) begin errors++; $display("FAIL addr_last_active: got %0d want 1607", vif.frame_read_address); end
        run_to(HA, 0, 1'b0);
        checks++;
        if (vif.frame_read_address !== 17'd0) begin errors++; $display("FAIL addr_hblank: got %0d want 0", vif.frame_read_address); end
    endtask

    task automatic test_latency();
        do_reset();
        checks++;
        if (vif.video_active !== 1'b0) begin errors++; $display("FAIL lat_t0: got %b want 0", vif.video_active); end
        step(1'b1, 1'b0);
        checks++;
        if (vif.video_active !== 1'b0) begin errors++; $display("FAIL lat_t1: got %b want 0", vif.video_active); end
        step(1'b1, 1'b0);
        checks++;
        if (vif.video_active !== 1'b1) begin errors++; $display("FAIL lat_t2: got %b want 1", vif.video_active); end
    endtask

    task automatic test_swap_held();
        int acks = 0;
        do_reset();
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1'b1, 1'b1);
            if (vif.swap_ack === 1'b1) acks++;
        end
        checks += 2;
        if (acks !== 1) begin errors++; $display("FAIL held_acks: got %0d want 1", acks); end
        if (vif.frame_select_memory !== 1'b1) begin errors++; $display("FAIL held_fsel: got %b want 1", vif.frame_select_memory); end
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        acks = 0;
        for (int i = 0; i < FRAME; i++) begin
            step(1'b1, 1'b1);
            if (vif.swap_ack === 1'b1) acks++;
        end
        checks += 2;
        if (acks !== 1) begin errors++; $display("FAIL reswap_acks: got %0d want 1", acks); end
        if (vif.frame_select_memory !== 1'b0) begin errors++; $display("FAIL reswap_fsel: got %b want 0", vif.frame_select_memory); end
    endtask

    task automatic test_swap_pulse();
        int acks = 0, ax = -1, ay = -1;
        do_reset();
        run_to(0, 3, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        for (int i = 0; i < FRAME; i++) begin
            step(1'b1, 1'b0);
            if (vif.swap_ack === 1'b1) begin acks++; ax = vif.pixel_x_pos; ay = vif.pixel_y_pos; end
        end
        checks += 4;
        if (acks !== 1) begin errors++; $display("FAIL pulse_acks: got %0d want 1", acks); end
        if (ax !== 0) begin errors++; $display("FAIL pulse_ack_x: got %0d want 0", ax); end
        if (ay !== VA) begin errors++; $display("FAIL pulse_ack_y: got %0d want %0d", ay, VA); end
        if (vif.frame_select_memory !== 1'b1) begin errors++; $display("FAIL pulse_fsel: got %b want 1", vif.frame_select_memory); end
    endtask

    task automatic test_same_cycle_request();
        int acks = 0;
        do_reset();
        run_to(HT - 1, VA - 1, 1'b0);
        step(1'b1, 1'b1);
        checks += 2;
        if (vif.swap_ack !== 1'b0) begin errors++; $display("FAIL same_cycle_ack: got %b want 0", vif.swap_ack); end
        if (vif.pixel_y_pos !== VA) begin errors++; $display("FAIL same_cycle_y: got %0d want %0d", vif.pixel_y_pos, VA); end
        for (int i = 0; i < FRAME; i++) begin
            step(1'b1, 1'b1);
            if (vif.swap_ack === 1'b1) acks++;
        end
        checks += 2;
        if (acks !== 1) begin errors++; $display("FAIL next_vblank_acks: got %0d want 1", acks); end
        if (vif.frame_select_memory !== 1'b1) begin errors++; $display("FAIL next_vblank_fsel: got %b want 1", vif.frame_select_memory); end
    endtask

    task automatic test_reset_pending();
        int acks = 0;
        do_reset();
        run_to(0, 2, 1'b0);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        reset = 1'b1;
        step(1'b0, 1'b0);
        reset = 1'b0;
        checks += 4;
        if (vif.pixel_x_pos !== 10'd0) begin errors++; $display("FAIL rst_pend_x: got %0d want 0", vif.pixel_x_pos); end
        if (vif.pixel_y_pos !== 10'd0) begin errors++; $display("FAIL rst_pend_y: got %0d want 0", vif.pixel_y_pos); end
        if (vif.frame_select_memory !== 1'b0) begin errors++; $display("FAIL rst_pend_fsel: got %b want 0", vif.frame_select_memory); end
        if (vif.swap_ack !== 1'b0) begin errors++; $display("FAIL rst_pend_ack: got %b want 0", vif.swap_ack); end
        for (int i = 0; i < FRAME; i++) begin
            step(1'b1, 1'b0);
            if (vif.swap_ack === 1'b1) acks++;
        end
        checks++;
        if (acks !== 0) begin errors++; $display("FAIL rst_pend_discard: got %0d acks want 0", acks); end
    endtask

    task automatic test_random();
        bit req = 1'b0;
        bit tick;
        do_reset();
        for (int c = 0; c < 2500; c++) begin
            tick = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 59) == 0) req = !req;
            if ($urandom_range(0, 999) == 0) reset = 1'b1;
            step(tick, req);
            reset = 1'b0;
            checks += 8;
            if (vif.pixel_x_pos !== ex_x()) begin errors++; $display("FAIL rnd_x: got %0d want %0d", vif.pixel_x_pos, ex_x()); end
            if (vif.pixel_y_pos !== ex_y()) begin errors++; $display("FAIL rnd_y: got %0d want %0d", vif.pixel_y_pos, ex_y()); end
            if (vif.frame_read_address !== ex_addr()) begin errors++; $display("FAIL rnd_addr: got %0d want %0d", vif.frame_read_address, ex_addr()); end
            if (vif.video_hsync !== ex_sync(0)) begin errors++; $display("FAIL rnd_hsync: got %b want %b", vif.video_hsync, ex_sync(0)); end
            if (vif.video_vsync !== ex_sync(1)) begin errors++; $display("FAIL rnd_vsync: got %b want %b", vif.video_vsync, ex_sync(1)); end
            if (vif.video_active !== ex_sync(2)) begin errors++; $display("FAIL rnd_active: got %b want %b", vif.video_active, ex_sync(2)); end
            if (vif.swap_ack !== m_ack) begin errors++; $display("FAIL rnd_ack: got %b want %b", vif.swap_ack, m_ack); end
            if (vif.frame_select_memory !== m_fsel) begin errors++; $display("FAIL rnd_fsel: got %b want %b", vif.frame_select_memory, m_fsel); end
`ifdef VIDEO_FRAME_COUNTER_EN
            checks++;
            if (vif.frame_count !== m_fc) begin errors++; $display("FAIL rnd_fcount: got %0d want %0d", vif.frame_count, m_fc); end
`endif
        end
    endtask

`ifdef VIDEO_FRAME_COUNTER_EN
    task automatic test_frame_count();
        do_reset();
        for (int i = 0; i < 2 * FRAME + VA * HT; i++) step(1'b1, 1'b0);
        checks++;
        if (vif.frame_count !== 16'd3) begin errors++; $display("FAIL frame_count: got %0d want 3", vif.frame_count); end
    endtask
`endif

    initial begin
        vif.pixel_tick   = 1'b0;
        vif.swap_request = 1'b0;
        m_t = 0; m_fsel = 0; m_ack = 0; m_armed = 0; m_rel = 0; m_fc = 0;
        @(negedge clock);
        test_reset();
        test_full_frame();
        test_sparse_tick();
        test_address_points();
        test_latency();
        test_swap_held();
        test_swap_pulse();
        test_same_cycle_request();
        test_reset_pending();
        test_random();
`ifdef VIDEO_FRAME_COUNTER_EN
        test_frame_count();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
